kmap_parity_sched: RTL

Round-robin scheduler that shares a single 4-input parity evaluator among NREQ requesters. The evaluator is the 4-variable checkerboard map, out = a^b^c^d. Each requester submits a WORD_W-bit word over a valid/ready handshake. The block feeds the word through the evaluator one nibble per cycle, accumulates the result, and returns the word parity tagged with the requester id. It sits between multiple client channels and the shared parity datapath.

---
 rtl/kmap_parity_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/kmap_parity_sched.sv
// kmap_parity_sched
//   Round-robin scheduler that shares one 4-input parity evaluator
//   (checkerboard map, a^b^c^d) among NREQ requesters. An accepted word is
//   fed through the evaluator one nibble per cycle, starting with bits 3:0.
//   The word parity is then returned together with the requester id.
//
// Optional build macro: KMAP_SCHED_ODD_EN
//   When it is defined, rsp_parity is inverted, which gives an odd-parity
//   check bit. When it is undefined, rsp_parity is even parity.
//   Timing and handshake are the same in both builds.
//
// Ports
//   clk         rising-edge clock
//   areset      asynchronous active-high reset
//   req_valid   per-requester word valid
//   req_ready   per-requester accept (one-hot or zero, IDLE only)
//   req_data    flattened words, requester i at [i*WORD_W +: WORD_W]
//   rsp_valid   result valid, held until rsp_ready
//   rsp_ready   result accepted by consumer
//   rsp_id      requester index of the result
//   rsp_parity  parity of the accepted word
//   busy        high while a word is in flight (RUN or DONE)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for any req_valid; grant is combinational round-robin
// RUN   | one evaluator pass per cycle, NIB passes in total
// DONE  | rsp_valid held until rsp_ready, then back to IDLE

module kmap_parity_sched #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_parity,
  output logic                     busy
);

  localparam int NIB   = WORD_W / 4;
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

`ifdef KMAP_SCHED_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   shift;
  logic                acc;
  logic [CNT_W-1:0]    cnt;
  logic [ID_W-1:0]     last_grant;

  logic [ID_W-1:0]     grant;
  logic                any_valid;
  logic [WORD_W-1:0]   sel_word;
  logic                pass_bit;

  function automatic logic p4(input logic [3:0] n);
    logic a, b, c, d;
    a = n[3];
    b = n[2];
    c = n[1];
    d = n[0];
    return a ^ b ^ c ^ d;
  endfunction

  assign any_valid = |req_valid;
  assign pass_bit  = p4(shift[3:0]);
  assign busy      = (state != S_IDLE);

  // Search upward from last_grant+1 (mod NREQ). The first valid requester
  // found wins.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_valid[j] && (((int'(last_grant) + k) % NREQ) == j)) begin
          found = 1'b1;
          grant = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_word  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        req_ready[i] = (state == S_IDLE) && any_valid;
        sel_word     = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_parity <= 1'b0;
      acc        <= 1'b0;
      cnt        <= '0;
      shift      <= '0;
      last_grant <= ID_W'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            shift      <= sel_word;
            rsp_id     <= grant;
            last_grant <= grant;
            acc        <= 1'b0;
            cnt        <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc ^ pass_bit;
          shift <= shift >> 4;
          cnt   <= cnt + 1'b1;
          // Publish on the final pass so the result lands with rsp_valid.
          if (cnt == CNT_LAST) begin
            rsp_parity <= acc ^ pass_bit ^ ODD;
            rsp_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
